// File: rtl/message_scroller.sv
// message_scroller: debounced button / timed scroll through a 16-digit hex message, four digits shown at a time.
// Ports: clk, reset (sync, active-high), button (raw, bouncing), auto (enable timed scroll),
//        char3..char0 (displayed digit codes, left to right), update (pulse when chars change), pos (message pointer).
module message_scroller #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] SCROLL_PERIOD   = 24'd4000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button,
  input  logic       auto,
  output logic [3:0] char3,
  output logic [3:0] char2,
  output logic [3:0] char1,
  output logic [3:0] char0,
  output logic       update,
  output logic [3:0] pos
);
  typedef enum logic [1:0] {RELEASED, CHK_PRESS, PRESSED, CHK_RELEASE} state_t;
  state_t state, state_d;
  logic s1, btn_s, press, tick, adv, adv_q;
  logic [15:0] cnt, cnt_d;
  logic [23:0] tcnt;
  function automatic logic [3:0] rom(input logic [3:0] i);
    return i;
  endfunction
  always_ff @(posedge clk)
    if (reset) {s1, btn_s} <= 2'b00;
    else {s1, btn_s} <= {button, s1};
  always_ff @(posedge clk)
    if (reset) begin
      state <= RELEASED;
      cnt <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
    end
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    press = 1'b0;
    case (state)
      RELEASED: if (btn_s) begin
        state_d = CHK_PRESS;
        cnt_d = '0;
      end
      CHK_PRESS: if (!btn_s) state_d = RELEASED;
        else if (cnt == DEBOUNCE_CYCLES - 16'd1) begin
          state_d = PRESSED;
          press = 1'b1;
        end else cnt_d = cnt + 16'd1;
      PRESSED: if (!btn_s) begin
        state_d = CHK_RELEASE;
        cnt_d = '0;
      end
      CHK_RELEASE: if (btn_s) state_d = PRESSED;
        else if (cnt == DEBOUNCE_CYCLES - 16'd1) state_d = RELEASED;
        else cnt_d = cnt + 16'd1;
      default: state_d = RELEASED;
    endcase
  end
  assign tick = auto && tcnt == SCROLL_PERIOD - 24'd1;
  assign adv = press | tick;
  // the timer wraps through adv, since a tick is itself an advance
  always_ff @(posedge clk)
    tcnt <= (reset || !auto || adv) ? '0 : tcnt + 24'd1;
  always_ff @(posedge clk)
    if (reset) begin
      pos <= '0;
      adv_q <= 1'b0;
      update <= 1'b0;
      {char3, char2, char1, char0} <= {4'h0, 4'h1, 4'h2, 4'h3};
    end else begin
      pos <= adv ? pos + 4'd1 : pos;
      adv_q <= adv;
      update <= adv_q;
      char3 <= rom(pos);
      char2 <= rom(pos + 4'd1);
      char1 <= rom(pos + 4'd2);
      char0 <= rom(pos + 4'd3);
    end
endmodule

// File: tb/tb_message_scroller.sv
// tb_message_scroller: randomized and directed check of message_scroller against a behavioural model.
module tb_message_scroller;
  localparam int D = 4;
  localparam int P = 8;
  logic clk = 1'b0, reset = 1'b1, button = 1'b0, auto = 1'b0;
  logic [3:0] char3, char2, char1, char0, pos;
  logic update;
  int tests = 0, fails = 0, n_upd = 0, base = 0, hold = 0;
  message_scroller #(.DEBOUNCE_CYCLES(16'd4), .SCROLL_PERIOD(24'd8)) dut (
    .clk(clk), .reset(reset), .button(button), .auto(auto),
    .char3(char3), .char2(char2), .char1(char1), .char0(char0),
    .update(update), .pos(pos)
  );
  always #5 clk = ~clk;
  logic [3:0] rom [16];
  logic [3:0] e_c [4];
  logic [3:0] m_pos;
  logic m_s1, m_bs, m_lvl, m_advq, e_upd, pr, tk, ad;
  int m_run, m_t;
  bit started = 0;
  initial for (int i = 0; i < 16; i++) rom[i] = 4'(i);
  always @(posedge clk) begin
    if (reset) begin
      m_s1 = 0; m_bs = 0; m_lvl = 0; m_run = 0; m_t = 0; m_pos = 0; m_advq = 0; e_upd = 0;
      for (int k = 0; k < 4; k++) e_c[k] = rom[k];
    end else begin
      pr = 0;
      if (m_bs != m_lvl) begin
        m_run++;
        if (m_run == D + 1) begin
          m_lvl = m_bs;
          m_run = 0;
          pr = m_lvl;
        end
      end else m_run = 0;
      tk = auto && m_t == P - 1;
      ad = pr || tk;
      m_t = (!auto || ad) ? 0 : m_t + 1;
      for (int k = 0; k < 4; k++) e_c[k] = rom[4'(m_pos + 4'(k))];
      e_upd = m_advq;
      m_advq = ad;
      if (ad) m_pos = m_pos + 4'd1;
      m_bs = m_s1;
      m_s1 = button;
    end
    started = 1;
  end
  task automatic chk(input string nm, input logic [3:0] a, input logic [3:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask
  always @(negedge clk)
    if (started) begin
      chk("pos", pos, m_pos);
      chk("char3", char3, e_c[0]);
      chk("char2", char2, e_c[1]);
      chk("char1", char1, e_c[2]);
      chk("char0", char0, e_c[3]);
      chk("update", {3'b0, update}, {3'b0, e_upd});
    end
  always @(posedge clk) #2 if (update === 1'b1) n_upd++;
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press1();
    button = 1; step(10);
    button = 0; step(10);
  endtask
  task automatic do_reset();
    reset = 1; step(2); reset = 0;
  endtask
  task automatic chk_chars(input string nm, input logic [15:0] e);
    chk({nm, "_c3"}, char3, e[15:12]);
    chk({nm, "_c2"}, char2, e[11:8]);
    chk({nm, "_c1"}, char1, e[7:4]);
    chk({nm, "_c0"}, char0, e[3:0]);
  endtask
  initial begin
    step(2); reset = 0;
    base = n_upd; step(20);
    chk("idle_pos", pos, 4'h0);
    chk_chars("idle", 16'h0123);
    chk("idle_upd", 4'(n_upd - base), 4'd0);
    base = n_upd;
    button = 1; step(1); button = 0; step(3);
    button = 1; step(1); button = 0; step(3);
    button = 1; step(10); button = 0; step(10);
    chk("bounce_pos", pos, 4'h1);
    chk_chars("bounce", 16'h1234);
    chk("bounce_upd", 4'(n_upd - base), 4'd1);
    do_reset();
    base = n_upd;
    for (int i = 1; i <= 16; i++) begin
      press1();
      if (i == 14) begin
        chk("wrap14_pos", pos, 4'hE);
        chk_chars("wrap14", 16'hEF01);
      end
    end
    chk("wrap_pos", pos, 4'h0);
    chk("wrap_upd", 4'(n_upd - base), 4'd0);
    chk("wrap_upd16", 4'((n_upd - base) >> 4), 4'd1);
    do_reset();
    base = n_upd;
    auto = 1; step(40); auto = 0; step(3);
    chk("auto_pos", pos, 4'h5);
    chk("auto_upd", 4'(n_upd - base), 4'd5);
    do_reset();
    base = n_upd;
    auto = 1; step(1);
    button = 1; step(7);
    chk("coin_pos", pos, 4'h1);
    step(7);
    chk("coin_hold", pos, 4'h1);
    step(1);
    chk("coin_next", pos, 4'h2);
    auto = 0; button = 0; step(10);
    chk("coin_upd", 4'(n_upd - base), 4'd2);
    do_reset();
    for (int i = 0; i < 5; i++) press1();
    chk("mid_pos5", pos, 4'h5);
    button = 1; step(3);
    reset = 1; button = 0; step(1); reset = 0;
    base = n_upd; step(12);
    chk("mid_pos", pos, 4'h0);
    chk_chars("mid", 16'h0123);
    chk("mid_upd", 4'(n_upd - base), 4'd0);
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        button = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 8);
      end
      hold--;
      if ($urandom_range(0, 19) == 0) auto = ~auto;
      reset = ($urandom_range(0, 199) == 0);
      step(1);
    end
    reset = 0; step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
